// File: rtl/relu_scheduler.sv
// Leaky-ReLU sequencer: streams a SIZE x SIZE matrix through a 1-cycle read port and writes activations.
// Optional RELU_MODE_EN adds relu_mode input selecting plain ReLU (1) or leaky ReLU (0).
module relu_scheduler #(
  parameter int WIDTH    = 16,
  parameter int SIZE     = 10,
  parameter int ADDR_W   = 8,
  parameter int LEAK_DIV = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic              hold,
`ifdef RELU_MODE_EN
  input  logic              relu_mode,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  localparam int NUM   = SIZE * SIZE;
  localparam int IDX_W = $clog2(NUM + 1);
  localparam logic signed [WIDTH-1:0] DIV = WIDTH'(LEAK_DIV);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
`ifdef RELU_MODE_EN
  logic                mode_q, mode_d;
`endif

  logic                     issue;
  logic signed [WIDTH-1:0]  x;
  logic signed [WIDTH-1:0]  act;

  // Signed division truncates toward zero, matching the required rounding.
  always_comb begin
    x   = $signed(rd_data);
    act = x;
    if (x < 0) begin
      act = x / DIV;
`ifdef RELU_MODE_EN
      if (mode_q) act = '0;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_d      = src_q;
    dst_d      = dst_q;
`ifdef RELU_MODE_EN
    mode_d     = mode_q;
`endif
    issue      = (state_q == ISSUE) && !hold;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          idx_d   = '0;
`ifdef RELU_MODE_EN
          mode_d  = relu_mode;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!hold) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM - 1)) state_d = DRAIN;
        end
      end
      // Leave DRAIN once stage 1 is empty: the final write then sits in stage 2,
      // so FIN (done) lands in the cycle right after that write.
      DRAIN: begin
        if (!s1_valid_q) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    s1_valid_d = issue;
    s1_addr_d  = dst_q + ADDR_W'(idx_q);
    wr_en_d    = s1_valid_q;
    wr_addr_d  = s1_valid_q ? s1_addr_q : '0;
    wr_data_d  = s1_valid_q ? act : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
`ifdef RELU_MODE_EN
      mode_q     <= 1'b0;
`endif
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
`ifdef RELU_MODE_EN
      mode_q     <= mode_d;
`endif
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign rd_en   = issue;
  assign rd_addr = issue ? (src_q + ADDR_W'(idx_q)) : '0;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign done    = (state_q == FIN);

endmodule
